// File: rtl/ptn_gen_multi_pkg.sv
// Shared mode encodings and colour masks for the multi-mode VGA pattern generator.
package ptn_gen_multi_pkg;

    typedef enum logic [2:0] {
        PTN_BARS  = 3'd0,
        PTN_GRAD  = 3'd1,
        PTN_CHECK = 3'd2,
        PTN_GRID  = 3'd3,
        PTN_BOX   = 3'd4
    } ptn_mode_e;

    // One bit per channel; expanded to full CW-bit saturation at the output.
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_mask_t;

    localparam rgb_mask_t RGB_BLACK = '{r: 1'b0, g: 1'b0, b: 1'b0};
    localparam rgb_mask_t RGB_WHITE = '{r: 1'b1, g: 1'b1, b: 1'b1};
    localparam rgb_mask_t RGB_RED   = '{r: 1'b1, g: 1'b0, b: 1'b0};
    localparam rgb_mask_t RGB_BLUE  = '{r: 1'b0, g: 1'b0, b: 1'b1};

    // Bar order white, yellow, cyan, green, magenta, red, blue, black
    // falls out of inverting individual index bits.
    function automatic rgb_mask_t bar_colour(input logic [2:0] idx);
        return '{r: ~idx[1], g: ~idx[2], b: ~idx[0]};
    endfunction

    function automatic logic mode_legal(input logic [2:0] m);
        return m <= 3'(PTN_BOX);
    endfunction

endpackage

// File: rtl/ptn_gen_multi_box.sv
// Bouncing-box position: steps each axis once per frame_tick, clamping and
// reversing at 0 and at the axis limit.
module ptn_box_mover #(
    parameter int CNT_W    = 10,
    parameter int H_LIMIT  = 608,
    parameter int V_LIMIT  = 448,
    parameter int BOX_STEP = 2
) (
    input  logic             pck,
    input  logic             rst,
    input  logic             frame_tick,
    output logic [CNT_W-1:0] box_x,
    output logic [CNT_W-1:0] box_y
);

    localparam logic [CNT_W-1:0] XL   = CNT_W'(H_LIMIT);
    localparam logic [CNT_W-1:0] YL   = CNT_W'(V_LIMIT);
    localparam logic [CNT_W-1:0] STEP = CNT_W'(BOX_STEP);

    logic dir_x;  // 1 = increasing
    logic dir_y;

    always_ff @(posedge pck) begin
        if (rst) begin
            box_x <= '0;
            box_y <= '0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (frame_tick) begin
            if (dir_x) begin
                if (box_x > XL - STEP) begin
                    box_x <= XL;
                    dir_x <= 1'b0;
                end else begin
                    box_x <= box_x + STEP;
                end
            end else if (box_x < STEP) begin
                box_x <= '0;
                dir_x <= 1'b1;
            end else begin
                box_x <= box_x - STEP;
            end

            if (dir_y) begin
                if (box_y > YL - STEP) begin
                    box_y <= YL;
                    dir_y <= 1'b0;
                end else begin
                    box_y <= box_y + STEP;
                end
            end else if (box_y < STEP) begin
                box_y <= '0;
                dir_y <= 1'b1;
            end else begin
                box_y <= box_y - STEP;
            end
        end
    end

endmodule

// File: rtl/ptn_gen_multi.sv
// Multi-mode VGA pattern generator, 2-PCK pipeline from syncgen timing to pins.
// Optional crosshair overlay enabled by defining PTN_CURSOR_EN.
module ptn_gen_multi
    import ptn_gen_multi_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CNT_W    = 10,
    parameter int CW       = 8,
    parameter int CHK_LOG2 = 5,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 2
) (
    input  logic             PCK,
    input  logic             RST,
    input  logic [CNT_W-1:0] HCNT,
    input  logic [CNT_W-1:0] VCNT,
    input  logic             DE_IN,
    input  logic             HSYNC_IN,
    input  logic             VSYNC_IN,
    input  logic [2:0]       MODE,
    input  logic             MODE_VLD,
`ifdef PTN_CURSOR_EN
    input  logic [CNT_W-1:0] CUR_X,
    input  logic [CNT_W-1:0] CUR_Y,
`endif
    output logic [CW-1:0]    VGA_R,
    output logic [CW-1:0]    VGA_G,
    output logic [CW-1:0]    VGA_B,
    output logic             DE_OUT,
    output logic             HSYNC_OUT,
    output logic             VSYNC_OUT,
    output logic [2:0]       MODE_ACT,
    output logic [15:0]      FRAME_CNT
);

    localparam int unsigned      BAR_W   = H_ACTIVE / 8;
    localparam logic [CNT_W:0]   BOX_EXT = (CNT_W+1)'(BOX_SIZE);

    logic [CNT_W-1:0] h_q, v_q, box_x, box_y;
    logic             de_q, hs_q, vs_q;
    logic             frame_tick, mode_ok, in_box, cursor_hit;
    ptn_mode_e        pending, mode_act;
    logic [2:0]       bar_idx;
    rgb_mask_t        mask;
    logic [CW-1:0]    px_r, px_g, px_b;

    assign frame_tick = (HCNT == '0) && (VCNT == CNT_W'(V_ACTIVE));
    assign mode_ok    = MODE_VLD && mode_legal(MODE);
    assign MODE_ACT   = mode_act;

    ptn_box_mover #(
        .CNT_W   (CNT_W),
        .H_LIMIT (H_ACTIVE - BOX_SIZE),
        .V_LIMIT (V_ACTIVE - BOX_SIZE),
        .BOX_STEP(BOX_STEP)
    ) u_box (
        .pck       (PCK),
        .rst       (RST),
        .frame_tick(frame_tick),
        .box_x     (box_x),
        .box_y     (box_y)
    );

`ifdef PTN_CURSOR_EN
    logic [CNT_W-1:0] cur_x_q, cur_y_q;

    // Cursor parked off-screen until the first frame boundary.
    always_ff @(posedge PCK) begin
        if (RST) begin
            cur_x_q <= '1;
            cur_y_q <= '1;
        end else if (frame_tick) begin
            cur_x_q <= CUR_X;
            cur_y_q <= CUR_Y;
        end
    end
    assign cursor_hit = (h_q == cur_x_q) || (v_q == cur_y_q);
`else
    assign cursor_hit = 1'b0;
`endif

    always_comb begin
        bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (h_q >= CNT_W'(k * BAR_W)) bar_idx = 3'(k);
        end
    end

    assign in_box = ({1'b0, h_q} >= {1'b0, box_x}) && ({1'b0, h_q} < {1'b0, box_x} + BOX_EXT) &&
                    ({1'b0, v_q} >= {1'b0, box_y}) && ({1'b0, v_q} < {1'b0, box_y} + BOX_EXT);

    always_comb begin
        mask = RGB_BLACK;
        case (mode_act)
            PTN_BARS:  mask = bar_colour(bar_idx);
            PTN_CHECK: mask = (h_q[CHK_LOG2] ^ v_q[CHK_LOG2]) ? RGB_WHITE : RGB_BLACK;
            PTN_GRID:  mask = ((h_q[CHK_LOG2-1:0] == '0) || (v_q[CHK_LOG2-1:0] == '0) ||
                               (h_q == CNT_W'(H_ACTIVE - 1)) || (v_q == CNT_W'(V_ACTIVE - 1)))
                              ? RGB_WHITE : RGB_BLACK;
            PTN_BOX:   mask = in_box ? RGB_RED : RGB_BLUE;
            default:   mask = RGB_BLACK;
        endcase
        if (mode_act == PTN_GRAD) begin
            px_r = h_q[CW-1:0];
            px_g = h_q[CW-1:0];
            px_b = h_q[CW-1:0];
        end else begin
            px_r = {CW{mask.r}};
            px_g = {CW{mask.g}};
            px_b = {CW{mask.b}};
        end
        if (cursor_hit) begin
            px_r = '0;
            px_g = '1;
            px_b = '0;
        end
    end

    always_ff @(posedge PCK) begin
        if (RST) begin
            h_q       <= '0;
            v_q       <= '0;
            de_q      <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            pending   <= PTN_BARS;
            mode_act  <= PTN_BARS;
            FRAME_CNT <= '0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            DE_OUT    <= 1'b0;
            HSYNC_OUT <= 1'b1;
            VSYNC_OUT <= 1'b1;
        end else begin
            h_q  <= HCNT;
            v_q  <= VCNT;
            de_q <= DE_IN;
            hs_q <= HSYNC_IN;
            vs_q <= VSYNC_IN;
            if (mode_ok) pending <= ptn_mode_e'(MODE);
            // A request landing on the tick itself bypasses pending.
            if (frame_tick) begin
                mode_act  <= mode_ok ? ptn_mode_e'(MODE) : pending;
                FRAME_CNT <= FRAME_CNT + 16'd1;
            end
            VGA_R     <= de_q ? px_r : '0;
            VGA_G     <= de_q ? px_g : '0;
            VGA_B     <= de_q ? px_b : '0;
            DE_OUT    <= de_q;
            HSYNC_OUT <= hs_q;
            VSYNC_OUT <= vs_q;
        end
    end

endmodule
